// File: rtl/cnn_window_serializer.sv
// Purpose : takes one KxK multi-channel window per input beat, drops edge-fill and
//           off-stride windows, and emits each kept window as K*K single-pixel taps.
// Latency : first tap is valid the cycle after the kept-window handshake; back-to-back windows have no bubble.
// Backpr. : s_tready is high in IDLE, or on a last-tap handshake; taps are held stable while m_tready is low.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_tdata/tvalid/tready  one full window [row][col][pixel] per beat, padded-raster order
//   m_tdata/tvalid/tready  one pixel (all channels) per beat, row-major inside the window
//   m_tlast             last tap of a window
//   m_tuser             first tap of output (0,0) of a frame
//   frame_done          1-cycle pulse after the last tap of output (OW-1,OH-1) is accepted
module cnn_window_serializer #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IN_CHANNELS  = 3,
    parameter int IMAGE_WIDTH  = 224,
    parameter int IMAGE_HEIGHT = 224,
    parameter int WINDOW_ROWS  = 3,
    parameter int WINDOW_COLS  = 3,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 1,
    parameter int DILATION     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [WINDOW_ROWS-1:0][WINDOW_COLS-1:0][PIXEL_WIDTH*IN_CHANNELS-1:0] s_tdata,
    input  logic s_tvalid,
    output logic s_tready,
    output logic [PIXEL_WIDTH*IN_CHANNELS-1:0] m_tdata,
    output logic m_tvalid,
    input  logic m_tready,
    output logic m_tlast,
    output logic m_tuser,
    output logic frame_done
);
    localparam int PW       = IMAGE_WIDTH + 2*PADDING;
    localparam int PH       = IMAGE_HEIGHT + 2*PADDING;
    localparam int EC       = 1 + (WINDOW_COLS-1)*DILATION;
    localparam int ER       = 1 + (WINDOW_ROWS-1)*DILATION;
    localparam int OW       = (PW-EC)/STRIDE + 1;
    localparam int OH       = (PH-ER)/STRIDE + 1;
    localparam int LAST_COL = EC-1 + (OW-1)*STRIDE;
    localparam int LAST_ROW = ER-1 + (OH-1)*STRIDE;
    localparam int NTAP     = WINDOW_ROWS*WINDOW_COLS;
    localparam int TW       = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int TRW      = (WINDOW_ROWS > 1) ? $clog2(WINDOW_ROWS) : 1;
    localparam int TCW      = (WINDOW_COLS > 1) ? $clog2(WINDOW_COLS) : 1;
    localparam int CW       = $clog2(PW);
    localparam int RW       = $clog2(PH);
    localparam int SPW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t state, state_nxt;

    logic [WINDOW_ROWS-1:0][WINDOW_COLS-1:0][PIXEL_WIDTH*IN_CHANNELS-1:0] win;
    logic [TW-1:0]  tap;
    logic [TRW-1:0] tap_row;
    logic [TCW-1:0] tap_col;
    logic           win_first, win_last;

    logic [CW-1:0]  in_col, nxt_col;
    logic [RW-1:0]  in_row, nxt_row;
    logic [SPW-1:0] col_ph, nxt_col_ph, row_ph, nxt_row_ph;
    logic           col_wrap, row_wrap, keep, is_first, is_last;
    logic           s_hs, m_hs, load, tap_adv;

    // Output side is a pure function of state and the tap pointer.
    assign m_tvalid = (state == SERIAL);
    assign m_tlast  = m_tvalid && (tap == TW'(NTAP-1));
    assign m_tuser  = m_tvalid && (tap == '0) && win_first;
    assign m_tdata  = m_tvalid ? win[tap_row][tap_col] : '0;

    // Accept a new window while the last tap leaves, so kept windows stream without a gap.
    assign s_tready = (state == IDLE) || (m_tlast && m_tready);
    assign s_hs     = s_tvalid && s_tready;
    assign m_hs     = m_tvalid && m_tready;

    // Raster position and stride phase of the window currently offered on s_tdata.
    // Phases restart at the first full-window position so no divider is needed;
    // tail positions past the last stride step land on a non-zero phase.
    always_comb begin
        col_wrap   = (in_col == CW'(PW-1));
        row_wrap   = (in_row == RW'(PH-1));
        nxt_col    = col_wrap ? '0 : in_col + CW'(1);
        nxt_row    = in_row;
        nxt_row_ph = row_ph;
        if (col_wrap) begin
            nxt_row = row_wrap ? '0 : in_row + RW'(1);
            if (nxt_row <= RW'(ER-1))
                nxt_row_ph = '0;
            else
                nxt_row_ph = (row_ph == SPW'(STRIDE-1)) ? '0 : row_ph + SPW'(1);
        end
        if (nxt_col <= CW'(EC-1))
            nxt_col_ph = '0;
        else
            nxt_col_ph = (col_ph == SPW'(STRIDE-1)) ? '0 : col_ph + SPW'(1);
        keep     = (in_col >= CW'(EC-1)) && (in_row >= RW'(ER-1)) &&
                   (col_ph == '0) && (row_ph == '0);
        is_first = (in_col == CW'(EC-1)) && (in_row == RW'(ER-1));
        is_last  = (in_col == CW'(LAST_COL)) && (in_row == RW'(LAST_ROW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        tap_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (s_hs && keep) begin
                    load      = 1'b1;
                    state_nxt = SERIAL;
                end
            end
            SERIAL: begin
                if (m_hs) begin
                    if (m_tlast) begin
                        if (s_hs && keep) load = 1'b1;
                        else              state_nxt = IDLE;
                    end else begin
                        tap_adv = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win        <= '0;
            tap        <= '0;
            tap_row    <= '0;
            tap_col    <= '0;
            win_first  <= 1'b0;
            win_last   <= 1'b0;
            in_col     <= '0;
            in_row     <= '0;
            col_ph     <= '0;
            row_ph     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= m_hs && m_tlast && win_last;
            if (s_hs) begin
                in_col <= nxt_col;
                in_row <= nxt_row;
                col_ph <= nxt_col_ph;
                row_ph <= nxt_row_ph;
            end
            if (load) begin
                win       <= s_tdata;
                tap       <= '0;
                tap_row   <= '0;
                tap_col   <= '0;
                win_first <= is_first;
                win_last  <= is_last;
            end else if (tap_adv) begin
                tap <= tap + TW'(1);
                if (tap_col == TCW'(WINDOW_COLS-1)) begin
                    tap_col <= '0;
                    tap_row <= tap_row + TRW'(1);
                end else begin
                    tap_col <= tap_col + TCW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cnn_window_serializer.sv
// Bench for cnn_window_serializer on a 4x4 image (6x6 padded raster), 3x3 window.
// Instance dut runs stride 1, instance dut2 runs stride 2; both share s_tdata and m_tready.
// Beats are collected by one monitor and compared to a geometry model afterwards.
module tb_cnn_window_serializer;
    typedef logic [2:0][2:0][23:0] win_t;

    logic clk = 1'b0;
    logic rst_n;
    win_t s_tdata;
    logic s_tvalid, s_tvalid2, s_tready, s_tready2;
    logic [23:0] m_tdata, m_tdata2;
    logic m_tvalid, m_tvalid2, m_tready, m_tlast, m_tlast2, m_tuser, m_tuser2;
    logic frame_done, frame_done2;

    int n_checks = 0;
    int n_fail   = 0;
    int beat_cnt = 0;
    int fd_cnt   = 0;
    int cyc      = 0;
    int msel     = 0;
    bit rand_rdy = 1'b0;

    logic [23:0] qd[$];
    bit          ql[$];
    bit          qu[$];
    int          qs[$];

    cnn_window_serializer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_done(frame_done)
    );

    cnn_window_serializer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .STRIDE(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid2), .s_tready(s_tready2),
        .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(m_tready),
        .m_tlast(m_tlast2), .m_tuser(m_tuser2), .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic win_t mk_win(input int mode, input int r, input int c);
        win_t w;
        for (int tr = 0; tr < 3; tr++)
            for (int tc = 0; tc < 3; tc++)
                w[tr][tc] = (mode == 0) ? 24'(r*6 + c) : {8'(r*6 + c), 8'(tr), 8'(tc)};
        return w;
    endfunction

    // Expected beat k: kept windows are row-major over the output grid.
    function automatic logic [23:0] exp_data(input int mode, input int stride, input int k);
        int w, t, n, r, c;
        w = k / 9;
        t = k % 9;
        n = 3 / stride + 1;
        r = 2 + (w / n) * stride;
        c = 2 + (w % n) * stride;
        return (mode == 0) ? 24'(r*6 + c) : {8'(r*6 + c), 8'(t / 3), 8'(t % 3)};
    endfunction

    always @(negedge clk) m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    // Monitor: samples 2 time units before the rising edge.
    logic [23:0] pd;
    bit pl, pu, pstall;
    always begin
        logic v, l, u, f;
        logic [23:0] d;
        @(negedge clk);
        #3;
        cyc++;
        v = msel ? m_tvalid2 : m_tvalid;
        d = msel ? m_tdata2 : m_tdata;
        l = msel ? m_tlast2 : m_tlast;
        u = msel ? m_tuser2 : m_tuser;
        f = msel ? frame_done2 : frame_done;
        if (!rst_n) begin
            pstall = 1'b0;
        end else begin
            if (pstall) begin
                chk("stall_vld", 32'(v), 32'd1);
                chk("stall_dat", 32'(d), 32'(pd));
                chk("stall_last", 32'(l), 32'(pl));
                chk("stall_user", 32'(u), 32'(pu));
            end
            if (v && m_tready) begin
                qd.push_back(d); ql.push_back(l); qu.push_back(u); qs.push_back(cyc);
                beat_cnt++;
            end
            pstall = v && !m_tready;
            pd = d; pl = l; pu = u;
            if (f) fd_cnt++;
        end
    end

    task automatic clear_q();
        qd.delete(); ql.delete(); qu.delete(); qs.delete();
        beat_cnt = 0;
        fd_cnt   = 0;
    endtask

    // Offers the 36 padded-raster windows of one frame; abort_at>0 returns early
    // once that many beats have been (or are about to be) accepted.
    task automatic drive_frame(input int sel, input int mode, input int abort_at);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                bit done;
                int budget;
                done = 1'b0;
                budget = 0;
                while (!done) begin
                    @(negedge clk);
                    s_tdata = mk_win(mode, r, c);
                    if (sel == 0) s_tvalid = 1'b1; else s_tvalid2 = 1'b1;
                    #4;
                    if (abort_at > 0 && beat_cnt >= abort_at) return;
                    done = (sel == 0) ? s_tready : s_tready2;
                    budget++;
                    if (budget > 100) begin
                        chk("src_timeout", 32'd0, 32'd1);
                        return;
                    end
                end
            end
        end
        @(negedge clk);
        s_tvalid  = 1'b0;
        s_tvalid2 = 1'b0;
    endtask

    task automatic check_frame(input string name, input int mode, input int stride);
        int nexp;
        nexp = ((stride == 1) ? 16 : 4) * 9;
        chk({name, "_beats"}, 32'(qd.size()), 32'(nexp));
        chk({name, "_frame_done"}, 32'(fd_cnt), 32'd1);
        for (int k = 0; k < qd.size() && k < nexp; k++) begin
            chk($sformatf("%s_dat%0d", name, k), 32'(qd[k]), 32'(exp_data(mode, stride, k)));
            chk($sformatf("%s_last%0d", name, k), 32'(ql[k]), 32'((k % 9) == 8));
            chk($sformatf("%s_user%0d", name, k), 32'(qu[k]), 32'(k == 0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        s_tvalid  = 1'b0;
        s_tvalid2 = 1'b0;
        s_tdata   = '0;
        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd1);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tuser", 32'(m_tuser), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Uniform taps, full rate.
        clear_q();
        drive_frame(0, 0, 0);
        repeat (60) @(negedge clk);
        check_frame("full", 0, 1);
        if (qs.size() >= 28) begin
            chk("no_bubble_w1", 32'(qs[9] - qs[8]), 32'd1);
            chk("no_bubble_w3", 32'(qs[27] - qs[26]), 32'd1);
        end else begin
            chk("no_bubble_beats", 32'(qs.size()), 32'd28);
        end

        // Distinct taps, random downstream stalls.
        rand_rdy = 1'b1;
        clear_q();
        drive_frame(0, 1, 0);
        repeat (200) @(negedge clk);
        check_frame("stall", 1, 1);
        rand_rdy = 1'b0;

        // Stride 2 instance, distinct taps.
        repeat (2) @(negedge clk);
        msel = 1;
        clear_q();
        drive_frame(1, 1, 0);
        repeat (60) @(negedge clk);
        check_frame("stride2", 1, 2);
        msel = 0;

        // Reset while tap 4 of the third kept window is on the output.
        clear_q();
        drive_frame(0, 0, 22);
        @(negedge clk);
        chk("pre_rst_tdata", 32'(m_tdata), 32'd16);
        rst_n     = 1'b0;
        s_tvalid  = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("mid_rst_s_tready", 32'(s_tready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        drive_frame(0, 0, 0);
        repeat (60) @(negedge clk);
        check_frame("after_rst", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
